cmp_sar_search: RTL and testbench

//  Successive-approximation search controller that drives the B operand of an external

---
 rtl/cmp_sar_search_pkg.sv | 28 ++
 rtl/cmp_sar_search_if.sv | 30 +++
 rtl/cmp_sar_search.sv | 111 +++++++++++
 tb/tb_cmp_sar_search.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cmp_sar_search_pkg.sv
// Shared types and flag decoding for the successive-approximation search controller.
package cmp_sar_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Decoded comparator verdict
    localparam logic [1:0] FLG_GT  = 2'd0;
    localparam logic [1:0] FLG_LT  = 2'd1;
    localparam logic [1:0] FLG_EQ  = 2'd2;
    localparam logic [1:0] FLG_BAD = 2'd3;

    // Only a solid 1 counts as asserted; X/Z read as false. Exactly one asserted flag is legal.
    function automatic logic [1:0] flag_decode(input logic gt, input logic lt, input logic eq);
        logic [2:0] f;
        f = {(gt === 1'b1), (lt === 1'b1), (eq === 1'b1)};
        case (f)
            3'b100:  flag_decode = FLG_GT;
            3'b010:  flag_decode = FLG_LT;
            3'b001:  flag_decode = FLG_EQ;
            default: flag_decode = FLG_BAD;
        endcase
    endfunction

endpackage

// File: rtl/cmp_sar_search_if.sv
// Bundle between the search controller (master) and its comparator / host side (slave).
interface cmp_sar_search_if #(
    parameter int WIDTH    = 4,
    parameter int MAXPROBE = WIDTH + 1
);
    localparam int PW = $clog2(MAXPROBE + 1);

    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [PW-1:0]    probes;

    modport master (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output guess, busy, done, found, err, result, probes
    );

    modport slave (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  guess, busy, done, found, err, result, probes
    );

endinterface

// File: rtl/cmp_sar_search.sv
// Binary-search controller: drives guess into an external comparator, one probe per clock,
// and reports the matched value, a failed search, or an illegal flag combination.
module cmp_sar_search
    import cmp_sar_search_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAXPROBE = WIDTH + 1
) (
    input logic               clk,
    input logic               rst_n,
    cmp_sar_search_if.master  bus
);

    localparam int PW = $clog2(MAXPROBE + 1);
    localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

    state_t           state;
    logic [WIDTH:0]   lo;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] guess_q;
    logic [PW-1:0]    probes_q;
    logic             found_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;

    logic [1:0]       flag;
    logic [PW-1:0]    probes_n;
    logic [WIDTH:0]   lo_n;
    logic [WIDTH:0]   hi_n;
    logic [WIDTH:0]   mid_sum;
    logic             exhausted;

    // Next search window from the current probe's verdict
    always_comb begin
        flag      = flag_decode(bus.cmp_gt, bus.cmp_lt, bus.cmp_eq);
        probes_n  = probes_q + 1'b1;
        lo_n      = lo;
        hi_n      = hi;
        if (flag == FLG_GT) lo_n = {1'b0, guess_q} + 1'b1;
        if (flag == FLG_LT) hi_n = {1'b0, guess_q} - 1'b1;
        mid_sum   = lo_n + hi_n;
        // lt at guess 0 would wrap hi; treat it as an empty window instead
        exhausted = ((flag == FLG_LT) && (guess_q == '0)) ||
                    (lo_n > hi_n) ||
                    (probes_n == PW'(MAXPROBE));
    end

    // Search FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            guess_q  <= '0;
            probes_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lo       <= '0;
                        hi       <= HI_INIT;
                        guess_q  <= HI_INIT[WIDTH:1];
                        probes_q <= '0;
                        found_q  <= 1'b0;
                        err_q    <= 1'b0;
                        result_q <= '0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    probes_q <= probes_n;
                    case (flag)
                        FLG_EQ: begin
                            found_q  <= 1'b1;
                            result_q <= guess_q;
                            state    <= FINISH;
                        end
                        FLG_BAD: begin
                            err_q <= 1'b1;
                            state <= FINISH;
                        end
                        default: begin
                            lo <= lo_n;
                            hi <= hi_n;
                            if (exhausted) begin
                                found_q <= 1'b0;
                                state   <= FINISH;
                            end else begin
                                guess_q <= mid_sum[WIDTH:1];
                            end
                        end
                    endcase
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FINISH);
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign bus.probes = probes_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// Directed bench for cmp_sar_search with a behavioural 4-bit comparator as responder.
module tb_cmp_sar_search;

    localparam int WIDTH    = 4;
    localparam int MAXPROBE = WIDTH + 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] target;
    int         fmode;      // 0: real comparator, 1: gt=lt=1, 2: all flags X
    int         n_checks;
    int         n_errors;

    cmp_sar_search_if #(.WIDTH(WIDTH), .MAXPROBE(MAXPROBE)) bus ();

    cmp_sar_search #(.WIDTH(WIDTH), .MAXPROBE(MAXPROBE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Comparator responder: A = target, B = guess
    assign bus.cmp_gt = (fmode == 0) ? (target > bus.guess)  : (fmode == 1) ? 1'b1 : 1'bx;
    assign bus.cmp_lt = (fmode == 0) ? (target < bus.guess)  : (fmode == 1) ? 1'b1 : 1'bx;
    assign bus.cmp_eq = (fmode == 0) ? (target == bus.guess) : (fmode == 1) ? 1'b0 : 1'bx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".guess"},  32'(bus.guess),  32'd0);
        check({tag, ".result"}, 32'(bus.result), 32'd0);
        check({tag, ".probes"}, 32'(bus.probes), 32'd0);
        check({tag, ".busy"},   32'(bus.busy),   32'd0);
        check({tag, ".done"},   32'(bus.done),   32'd0);
        check({tag, ".found"},  32'(bus.found),  32'd0);
        check({tag, ".err"},    32'(bus.err),    32'd0);
    endtask

    // exp_g holds expected guesses, first probe in bits [3:0]
    task automatic run_search(input string tag, input logic [3:0] tgt, input int mode,
                              input int exp_n, input logic [19:0] exp_g,
                              input logic exp_found, input logic [3:0] exp_result,
                              input logic exp_err, input logic pulse_mid);
        logic [3:0] seen [8];
        logic [3:0] eg;
        int n;
        int cycles;
        target = tgt;
        fmode  = mode;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        n = 0;
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            if (bus.busy) begin
                if (n < 8) seen[n] = bus.guess;
                n++;
            end
            bus.start = (pulse_mid && cycles == 0);
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        if (cycles >= 20) check({tag, ".timeout"}, 32'd1, 32'd0);
        check({tag, ".done"},   32'(bus.done),   32'd1);
        check({tag, ".busy"},   32'(bus.busy),   32'd1);
        check({tag, ".found"},  32'(bus.found),  32'(exp_found));
        check({tag, ".result"}, 32'(bus.result), 32'(exp_result));
        check({tag, ".err"},    32'(bus.err),    32'(exp_err));
        check({tag, ".probes"}, 32'(bus.probes), 32'(exp_n));
        check({tag, ".nguess"}, 32'(n),          32'(exp_n));
        for (int i = 0; i < exp_n && i < n && i < 5; i++) begin
            eg = exp_g[i*4 +: 4];
            check($sformatf("%s.guess%0d", tag, i), 32'(seen[i]), 32'(eg));
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done),   32'd0);
        check({tag, ".idle_busy"},  32'(bus.busy),   32'd0);
        check({tag, ".hold_found"}, 32'(bus.found),  32'(exp_found));
        check({tag, ".hold_res"},   32'(bus.result), 32'(exp_result));
        check({tag, ".hold_err"},   32'(bus.err),    32'(exp_err));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        target    = 4'd0;
        fmode     = 0;
        #12;
        check_idle_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("idle_no_start");

        run_search("t11", 4'd11, 0, 2, 20'h000B7, 1'b1, 4'd11, 1'b0, 1'b0);
        run_search("t0",  4'd0,  0, 4, 20'h00137, 1'b1, 4'd0,  1'b0, 1'b0);
        run_search("t15", 4'd15, 0, 5, 20'hFEDB7, 1'b1, 4'd15, 1'b0, 1'b0);
        run_search("gtlt", 4'd5, 1, 1, 20'h00007, 1'b0, 4'd0,  1'b1, 1'b0);
        run_search("xflg", 4'd5, 2, 1, 20'h00007, 1'b0, 4'd0,  1'b1, 1'b1);
        run_search("t4_midstart", 4'd4, 0, 4, 20'h04537, 1'b1, 4'd4, 1'b0, 1'b1);

        // Abort during the second probe of a target-11 search
        target = 4'd11;
        fmode  = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("abort.probe1_guess", 32'(bus.guess), 32'd7);
        @(negedge clk);
        check("abort.probe2_guess", 32'(bus.guess), 32'd11);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        check("abort.no_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("abort.no_done2", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("abort_release");
        run_search("t11_again", 4'd11, 0, 2, 20'h000B7, 1'b1, 4'd11, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
